// File: rtl/decoder_pkg.sv
// decoder_pkg: shared RV32IMA+S decode types, opcode/funct constants, op-flag record and FSM states
package decoder_pkg;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_OP = 7'b0110011, OP_MISC_MEM = 7'b0001111, OP_SYSTEM = 7'b1110011, OP_AMO = 7'b0101111;
  localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20, F7_MULDIV = 7'h01, F7_SFENCE = 7'h09;
  localparam logic [2:0] F3_W = 3'd2;
  localparam logic [4:0] F5_LR = 5'b00010, F5_SC = 5'b00011, F5_SWAP = 5'b00001, F5_ADD = 5'b00000;
  localparam logic [4:0] F5_XOR = 5'b00100, F5_AND = 5'b01100, F5_OR = 5'b01000, F5_MIN = 5'b10000;
  localparam logic [4:0] F5_MAX = 5'b10100, F5_MINU = 5'b11000, F5_MAXU = 5'b11100;
  localparam logic [31:0] W_ECALL = 32'h00000073, W_EBREAK = 32'h00100073, W_SRET = 32'h10200073;
  localparam logic [31:0] W_MRET = 32'h30200073, W_WFI = 32'h10500073;
  typedef struct packed {
    logic lui, auipc, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu;
    logic lb, lh, lw, lbu, lhu, sb, sh, sw;
    logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
    logic add, sub, sll, slt, sltu, xor_, srl, sra, or_, and_;
    logic fence, fence_i, ecall, ebreak, mret, sret, wfi, sfence_vma;
    logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
    logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
    logic lr_w, sc_w, amoswap_w, amoadd_w, amoxor_w, amoand_w, amoor_w;
    logic amomin_w, amomax_w, amominu_w, amomaxu_w;
  } ops_t;
  typedef struct packed {
    ops_t        op;
    logic [31:0] imm;
    logic [31:0] pc;
  } instructions;
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;
  typedef enum logic {IDLE, DONE} state_e;
endpackage

// File: rtl/decoder_imm_gen.sv
// decoder_imm_gen: sign-extended immediates of every format from instr_raw[31:7] (in), one 32-bit value per format (out)
module decoder_imm_gen (
  input  logic [31:7] instr_raw,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j,
  output logic [31:0] imm_z
);
  assign imm_i = {{20{instr_raw[31]}}, instr_raw[31:20]};
  assign imm_s = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
  assign imm_b = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7], instr_raw[30:25], instr_raw[11:8], 1'b0};
  assign imm_u = {instr_raw[31:12], 12'b0};
  assign imm_j = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12], instr_raw[20], instr_raw[30:21], 1'b0};
  assign imm_z = {27'b0, instr_raw[19:15]};
endmodule

// File: rtl/decoder.sv
// decoder: registered RV32IMA+S decode; in clk/rst/enabled/flush/pc/instr_raw, out completed pulse, instr record, rs1/rs2/rd_idx, writes_rd, illegal
module decoder
  import decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic [31:0] instr_raw,
  output logic        completed,
  output instructions instr,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [4:0]  rd_idx,
  output logic        writes_rd,
  output logic        illegal
);
  state_e state_q, state_d;
  ops_t op_d;
  logic [6:0] opc, f7;
  logic [4:0] rs1, rs2, rd, f5;
  logic [2:0] f3;
  logic is_br, is_ld, is_st, is_oi, is_op, is_mm, is_sy, is_am, b_op, a_op, m_op;
  logic legal, has_rs1, has_rs2, has_rd;
  logic [31:0] imm_d, imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  assign {f7, rs2, rs1, f3, rd, opc} = instr_raw;
  assign f5 = f7[6:2];
  assign is_br = opc == OP_BRANCH;
  assign is_ld = opc == OP_LOAD;
  assign is_st = opc == OP_STORE;
  assign is_oi = opc == OP_IMM;
  assign is_op = opc == OP_OP;
  assign is_mm = opc == OP_MISC_MEM;
  assign is_sy = opc == OP_SYSTEM;
  assign is_am = opc == OP_AMO && f3 == F3_W;
  assign b_op = is_op && f7 == F7_BASE;
  assign a_op = is_op && f7 == F7_ALT;
  assign m_op = is_op && f7 == F7_MULDIV;
  decoder_imm_gen u_imm (
    .instr_raw(instr_raw[31:7]),
    .imm_i(imm_i),
    .imm_s(imm_s),
    .imm_b(imm_b),
    .imm_u(imm_u),
    .imm_j(imm_j),
    .imm_z(imm_z)
  );
  always_comb begin
    op_d = '0;
    op_d.lui = opc == OP_LUI;
    op_d.auipc = opc == OP_AUIPC;
    op_d.jal = opc == OP_JAL;
    op_d.jalr = opc == OP_JALR && f3 == 3'd0;
    op_d.beq = is_br && f3 == 3'd0;  op_d.bne = is_br && f3 == 3'd1;
    op_d.blt = is_br && f3 == 3'd4;  op_d.bge = is_br && f3 == 3'd5;
    op_d.bltu = is_br && f3 == 3'd6; op_d.bgeu = is_br && f3 == 3'd7;
    op_d.lb = is_ld && f3 == 3'd0;   op_d.lh = is_ld && f3 == 3'd1;   op_d.lw = is_ld && f3 == 3'd2;
    op_d.lbu = is_ld && f3 == 3'd4;  op_d.lhu = is_ld && f3 == 3'd5;
    op_d.sb = is_st && f3 == 3'd0;   op_d.sh = is_st && f3 == 3'd1;   op_d.sw = is_st && f3 == 3'd2;
    op_d.addi = is_oi && f3 == 3'd0; op_d.slti = is_oi && f3 == 3'd2; op_d.sltiu = is_oi && f3 == 3'd3;
    op_d.xori = is_oi && f3 == 3'd4; op_d.ori = is_oi && f3 == 3'd6;  op_d.andi = is_oi && f3 == 3'd7;
    op_d.slli = is_oi && f3 == 3'd1 && f7 == F7_BASE;
    op_d.srli = is_oi && f3 == 3'd5 && f7 == F7_BASE;
    op_d.srai = is_oi && f3 == 3'd5 && f7 == F7_ALT;
    op_d.add = b_op && f3 == 3'd0;   op_d.sll = b_op && f3 == 3'd1;   op_d.slt = b_op && f3 == 3'd2;
    op_d.sltu = b_op && f3 == 3'd3;  op_d.xor_ = b_op && f3 == 3'd4;  op_d.srl = b_op && f3 == 3'd5;
    op_d.or_ = b_op && f3 == 3'd6;   op_d.and_ = b_op && f3 == 3'd7;
    op_d.sub = a_op && f3 == 3'd0;   op_d.sra = a_op && f3 == 3'd5;
    op_d.mul = m_op && f3 == 3'd0;   op_d.mulh = m_op && f3 == 3'd1;  op_d.mulhsu = m_op && f3 == 3'd2;
    op_d.mulhu = m_op && f3 == 3'd3; op_d.div = m_op && f3 == 3'd4;   op_d.divu = m_op && f3 == 3'd5;
    op_d.rem = m_op && f3 == 3'd6;   op_d.remu = m_op && f3 == 3'd7;
    op_d.fence = is_mm && f3 == 3'd0;
    op_d.fence_i = is_mm && f3 == 3'd1;
    op_d.ecall = instr_raw == W_ECALL; op_d.ebreak = instr_raw == W_EBREAK;
    op_d.mret = instr_raw == W_MRET;   op_d.sret = instr_raw == W_SRET;  op_d.wfi = instr_raw == W_WFI;
    op_d.sfence_vma = is_sy && f3 == 3'd0 && f7 == F7_SFENCE;
    op_d.csrrw = is_sy && f3 == 3'd1;  op_d.csrrs = is_sy && f3 == 3'd2;  op_d.csrrc = is_sy && f3 == 3'd3;
    op_d.csrrwi = is_sy && f3 == 3'd5; op_d.csrrsi = is_sy && f3 == 3'd6; op_d.csrrci = is_sy && f3 == 3'd7;
    op_d.lr_w = is_am && f5 == F5_LR;      op_d.sc_w = is_am && f5 == F5_SC;
    op_d.amoswap_w = is_am && f5 == F5_SWAP; op_d.amoadd_w = is_am && f5 == F5_ADD;
    op_d.amoxor_w = is_am && f5 == F5_XOR; op_d.amoand_w = is_am && f5 == F5_AND;
    op_d.amoor_w = is_am && f5 == F5_OR;   op_d.amomin_w = is_am && f5 == F5_MIN;
    op_d.amomax_w = is_am && f5 == F5_MAX; op_d.amominu_w = is_am && f5 == F5_MINU;
    op_d.amomaxu_w = is_am && f5 == F5_MAXU;
    legal = |op_d;
    has_rs1 = legal && (opc == OP_JALR || is_br || is_ld || is_st || is_oi || is_op || is_am || (is_sy && f3 != 3'd0 && !f3[2]) || op_d.sfence_vma);
    has_rs2 = legal && (is_br || is_st || is_op || is_am || op_d.sfence_vma);
    has_rd = legal && (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR} || is_ld || is_oi || is_op || is_am || (is_sy && f3 != 3'd0));
    imm_d = !legal ? '0 : (opc == OP_JALR || is_ld || is_oi) ? imm_i : is_st ? imm_s : is_br ? imm_b :
            (opc == OP_LUI || opc == OP_AUIPC) ? imm_u : opc == OP_JAL ? imm_j : (is_sy && f3[2]) ? imm_z : '0;
  end
  always_comb begin
    state_d = (enabled && !flush) ? DONE : IDLE;
    completed = state_q == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      instr <= '0;
      rs1_idx <= '0;
      rs2_idx <= '0;
      rd_idx <= '0;
      writes_rd <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == DONE) begin
        instr <= {op_d, imm_d, pc};
        rs1_idx <= has_rs1 ? rs1 : '0;
        rs2_idx <= has_rs2 ? rs2 : '0;
        rd_idx <= has_rd ? rd : '0;
        writes_rd <= has_rd && rd != 5'd0;
        illegal <= !legal;
      end
    end
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: table-driven scoreboard bench for decoder
module tb_decoder;
  import decoder_pkg::*;
  logic clk = 1'b0, rst = 1'b1, enabled = 1'b0, flush = 1'b0;
  logic [31:0] pc = '0, instr_raw = '0;
  logic completed, writes_rd, illegal;
  instructions instr;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;
  decoder dut (
    .clk(clk),
    .rst(rst),
    .enabled(enabled),
    .flush(flush),
    .pc(pc),
    .instr_raw(instr_raw),
    .completed(completed),
    .instr(instr),
    .rs1_idx(rs1_idx),
    .rs2_idx(rs2_idx),
    .rd_idx(rd_idx),
    .writes_rd(writes_rd),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] raw, pc, imm;
    ops_t op;
    logic [4:0] rs1, rs2, rd;
    logic wr, ill;
  } vec_t;
  vec_t tbl[$];
  vec_t q[$];
  vec_t mon_e;
  int total = 0, bad = 0;
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask
  task automatic check_out(input vec_t e);
    chk($sformatf("%h.op", e.raw), instr.op, e.op);
    chk($sformatf("%h.imm", e.raw), instr.imm, e.imm);
    chk($sformatf("%h.pc", e.raw), instr.pc, e.pc);
    chk($sformatf("%h.rs1", e.raw), rs1_idx, e.rs1);
    chk($sformatf("%h.rs2", e.raw), rs2_idx, e.rs2);
    chk($sformatf("%h.rd", e.raw), rd_idx, e.rd);
    chk($sformatf("%h.writes_rd", e.raw), writes_rd, e.wr);
    chk($sformatf("%h.illegal", e.raw), illegal, e.ill);
  endtask
  task automatic add(input logic [31:0] raw, input ops_t op, input logic [31:0] imm, input int r1, input int r2, input int rd, input logic wr, input logic ill);
    vec_t v;
    v.raw = raw; v.pc = 32'h100 + 32'(4 * tbl.size()); v.op = op; v.imm = imm;
    v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.rd = 5'(rd); v.wr = wr; v.ill = ill;
    tbl.push_back(v);
  endtask
  always @(negedge clk)
    if (completed) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_completed got=1 want=0");
      end else begin
        mon_e = q.pop_front();
        check_out(mon_e);
      end
    end
  initial begin
    ops_t o;
    vec_t z, last;
    o = '0; o.addi = 1'b1;       add(32'hFFF10093, o, 32'hFFFFFFFF, 2, 0, 1, 1, 0);
    o = '0; o.lui = 1'b1;        add(32'h123452B7, o, 32'h12345000, 0, 0, 5, 1, 0);
    o = '0; o.jal = 1'b1;        add(32'hFFDFF0EF, o, 32'hFFFFFFFC, 0, 0, 1, 1, 0);
    o = '0; o.beq = 1'b1;        add(32'h00208463, o, 32'h00000008, 1, 2, 0, 0, 0);
    o = '0; o.mul = 1'b1;        add(32'h022081B3, o, 32'h00000000, 1, 2, 3, 1, 0);
    add(32'h00000000, '0, 32'h0, 0, 0, 0, 0, 1);
    add(32'h40001033, '0, 32'h0, 0, 0, 0, 0, 1);
    add(32'h20208033, '0, 32'h0, 0, 0, 0, 0, 1);
    o = '0; o.sub = 1'b1;        add(32'h402081B3, o, 32'h00000000, 1, 2, 3, 1, 0);
    o = '0; o.add = 1'b1;        add(32'h00208033, o, 32'h00000000, 1, 2, 0, 0, 0);
    o = '0; o.sw = 1'b1;         add(32'h0020A423, o, 32'h00000008, 1, 2, 0, 0, 0);
    o = '0; o.lw = 1'b1;         add(32'hFFC0A203, o, 32'hFFFFFFFC, 1, 0, 4, 1, 0);
    o = '0; o.srai = 1'b1;       add(32'h40335293, o, 32'h00000403, 6, 0, 5, 1, 0);
    add(32'h40331293, '0, 32'h0, 0, 0, 0, 0, 1);
    o = '0; o.auipc = 1'b1;      add(32'hFFFFF397, o, 32'hFFFFF000, 0, 0, 7, 1, 0);
    o = '0; o.jalr = 1'b1;       add(32'h00008067, o, 32'h00000000, 1, 0, 0, 0, 0);
    o = '0; o.ecall = 1'b1;      add(32'h00000073, o, 32'h00000000, 0, 0, 0, 0, 0);
    o = '0; o.mret = 1'b1;       add(32'h30200073, o, 32'h00000000, 0, 0, 0, 0, 0);
    o = '0; o.csrrwi = 1'b1;     add(32'h3002D0F3, o, 32'h00000005, 0, 0, 1, 1, 0);
    o = '0; o.csrrs = 1'b1;      add(32'h3001A173, o, 32'h00000000, 3, 0, 2, 1, 0);
    o = '0; o.amoadd_w = 1'b1;   add(32'h0020A2AF, o, 32'h00000000, 1, 2, 5, 1, 0);
    o = '0; o.lr_w = 1'b1;       add(32'h1400A2AF, o, 32'h00000000, 1, 0, 5, 1, 0);
    add(32'h0020B2AF, '0, 32'h0, 0, 0, 0, 0, 1);
    o = '0; o.sfence_vma = 1'b1; add(32'h12208073, o, 32'h00000000, 1, 2, 0, 0, 0);
    o = '0; o.fence_i = 1'b1;    add(32'h0000100F, o, 32'h00000000, 0, 0, 0, 0, 0);
    o = '0; o.bne = 1'b1;        add(32'hFE4198E3, o, 32'hFFFFFFF0, 3, 4, 0, 0, 0);
    o = '0; o.wfi = 1'b1;        add(32'h10500073, o, 32'h00000000, 0, 0, 0, 0, 0);
    add(32'h00004073, '0, 32'h0, 0, 0, 0, 0, 1);
    z.raw = '0; z.pc = '0; z.imm = '0; z.op = '0; z.rs1 = '0; z.rs2 = '0; z.rd = '0; z.wr = 1'b0; z.ill = 1'b0;
    #1;
    chk("reset.completed", completed, 1'b0);
    check_out(z);
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (tbl[i]) begin
      enabled = 1'b1; instr_raw = tbl[i].raw; pc = tbl[i].pc;
      q.push_back(tbl[i]);
      @(posedge clk); #1;
    end
    enabled = 1'b0;
    last = tbl[tbl.size() - 1];
    repeat (3) @(posedge clk);
    #1;
    chk("hold.completed", completed, 1'b0);
    check_out(last);
    enabled = 1'b1; flush = 1'b1; instr_raw = 32'hFFF10093; pc = 32'hDEAD0000;
    @(posedge clk); #1;
    enabled = 1'b0; flush = 1'b0;
    chk("flush.completed", completed, 1'b0);
    check_out(last);
    @(posedge clk); #1;
    chk("flush.completed_late", completed, 1'b0);
    enabled = 1'b1; instr_raw = 32'hFFF10093; pc = 32'h200;
    @(posedge clk);
    enabled = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreset.completed", completed, 1'b0);
    check_out(z);
    @(posedge clk); #1;
    rst = 1'b0;
    enabled = 1'b1; instr_raw = tbl[1].raw; pc = tbl[1].pc;
    q.push_back(tbl[1]);
    @(posedge clk); #1;
    enabled = 1'b0;
    chk("post_reset.completed", completed, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
